// File: rtl/enc_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package enc_pkg;

  typedef enum logic [2:0] {
    FMT_R  = 3'd0,
    FMT_I  = 3'd1,
    FMT_S  = 3'd2,
    FMT_SB = 3'd3,
    FMT_U  = 3'd4,
    FMT_UJ = 3'd5
  } fmt_e;

  localparam logic [6:0] OPC_I_COMP  = 7'h13;
  localparam logic [6:0] OPC_I_LOAD  = 7'h03;
  localparam logic [6:0] OPC_I_JALR  = 7'h67;
  localparam logic [6:0] OPC_S       = 7'h23;
  localparam logic [6:0] OPC_SB      = 7'h63;
  localparam logic [6:0] OPC_U_LUI   = 7'h37;
  localparam logic [6:0] OPC_U_AUIPC = 7'h17;
  localparam logic [6:0] OPC_UJ      = 7'h6F;

  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO; full/empty come from an extra pointer wrap bit.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign rdata = mem[rd_ptr[AW-1:0]];

  // Storage is cleared on reset so the read port shows zero while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/inst_encoder.sv
// Packs RV32I fields plus an immediate into an instruction word, buffered by a FIFO.
// Optional immediate range checking is enabled with `define IMM_RANGE_CHK_EN.
module inst_encoder
  import enc_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       fmt,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [2:0]       funct3,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      inst,
  output logic             err,
  output logic [CNT_W-1:0] enc_count
);

  function automatic logic [32:0] pack(
    input logic [2:0]  f,
    input logic [6:0]  opc,
    input logic [4:0]  f_rd,
    input logic [2:0]  f3,
    input logic [4:0]  f_rs1,
    input logic [4:0]  f_rs2,
    input logic [6:0]  f7,
    input logic [31:0] im
  );
    logic [31:0] w;
    logic        e;
    w = NOP;
    e = 1'b0;
    case (f)
      FMT_R:   w = {f7, f_rs2, f_rs1, f3, f_rd, opc};
      FMT_I:   w = {im[11:0], f_rs1, f3, f_rd, opc};
      FMT_S:   w = {im[11:5], f_rs2, f_rs1, f3, im[4:0], opc};
      FMT_SB:  w = {im[12], im[10:5], f_rs2, f_rs1, f3, im[4:1], im[11], opc};
      FMT_U:   w = {im[31:12], f_rd, opc};
      FMT_UJ:  w = {im[20], im[10:1], im[11], im[19:12], f_rd, opc};
      default: w = NOP;
    endcase
`ifdef IMM_RANGE_CHK_EN
    // A value fits when every bit above the field's sign bit copies it.
    case (f)
      FMT_I, FMT_S: e = (im[31:11] != {21{im[11]}});
      FMT_SB:       e = (im[31:12] != {20{im[12]}}) || im[0];
      FMT_UJ:       e = (im[31:20] != {12{im[20]}}) || im[0];
      FMT_U:        e = (im[11:0] != 12'h000);
      default:      e = 1'b0;
    endcase
`endif
    return {e, w};
  endfunction

`ifndef IMM_RANGE_CHK_EN
  logic unused_imm_lsb;
  assign unused_imm_lsb = imm[0];
`endif

  logic        push;
  logic        pop;
  logic        full;
  logic        empty;
  logic [32:0] wdata;
  logic [32:0] rdata;

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign wdata     = pack(fmt, opcode, rd, funct3, rs1, rs2, funct7, imm);
  assign inst      = rdata[31:0];
  assign err       = rdata[32];

  sync_fifo #(
    .WIDTH (33),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .wdata (wdata),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

  // Completed output handshake counter, wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      enc_count <= '0;
    end else if (pop) begin
      enc_count <= enc_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_inst_encoder.sv
// Scoreboard bench for inst_encoder: random bundles vs an arithmetic reference model.
module tb_inst_encoder;
  import enc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] inst;
  logic        err;
  logic [31:0] enc_count;

  always #5 clk = ~clk;

  inst_encoder dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .fmt(fmt), .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1),
    .rs2(rs2), .funct7(funct7), .imm(imm), .out_valid(out_valid),
    .out_ready(out_ready), .inst(inst), .err(err), .enc_count(enc_count)
  );

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } bundle_t;

  typedef struct {
    logic [31:0] inst;
    logic        err;
    logic [2:0]  fmt;
    logic [31:0] imm;
    bit          rt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_cnt = 32'd0;
  bit          rand_done;

`ifdef IMM_RANGE_CHK_EN
  localparam bit CHK_ON = 1'b1;
`else
  localparam bit CHK_ON = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] f(input logic [31:0] v, input int sh, input logic [31:0] mask);
    return ((v >> sh) & mask);
  endfunction

  // Reference encoding from the field placement rules, using shifts and masks.
  function automatic exp_t model(input bundle_t b);
    exp_t        e;
    logic [31:0] base;
    int          s;
    bit          ok;
    s    = $signed(b.imm);
    base = 32'(b.opc);
    ok   = 1'b1;
    case (b.fmt)
      3'd0: e.inst = base | (32'(b.rd) << 7) | (32'(b.f3) << 12) | (32'(b.rs1) << 15)
                     | (32'(b.rs2) << 20) | (32'(b.f7) << 25);
      3'd1: begin
        e.inst = base | (32'(b.rd) << 7) | (32'(b.f3) << 12) | (32'(b.rs1) << 15)
                 | (f(b.imm, 0, 32'hFFF) << 20);
        ok = (s >= -2048) && (s <= 2047);
      end
      3'd2: begin
        e.inst = base | (f(b.imm, 0, 32'h1F) << 7) | (32'(b.f3) << 12) | (32'(b.rs1) << 15)
                 | (32'(b.rs2) << 20) | (f(b.imm, 5, 32'h7F) << 25);
        ok = (s >= -2048) && (s <= 2047);
      end
      3'd3: begin
        e.inst = base | (f(b.imm, 11, 32'h1) << 7) | (f(b.imm, 1, 32'hF) << 8)
                 | (32'(b.f3) << 12) | (32'(b.rs1) << 15) | (32'(b.rs2) << 20)
                 | (f(b.imm, 5, 32'h3F) << 25) | (f(b.imm, 12, 32'h1) << 31);
        ok = (s >= -4096) && (s <= 4095) && (s % 2 == 0);
      end
      3'd4: begin
        e.inst = base | (32'(b.rd) << 7) | (b.imm & 32'hFFFF_F000);
        ok = (b.imm % 4096) == 0;
      end
      3'd5: begin
        e.inst = base | (32'(b.rd) << 7) | (f(b.imm, 12, 32'hFF) << 12)
                 | (f(b.imm, 11, 32'h1) << 20) | (f(b.imm, 1, 32'h3FF) << 21)
                 | (f(b.imm, 20, 32'h1) << 31);
        ok = (s >= -1048576) && (s <= 1048575) && (s % 2 == 0);
      end
      default: e.inst = 32'h0000_0013;
    endcase
    e.err = CHK_ON && !ok;
    e.fmt = b.fmt;
    e.imm = b.imm;
    e.rt  = ok && (b.fmt >= 3'd1) && (b.fmt <= 3'd5);
    return e;
  endfunction

  // Immediate generator: recovers the immediate from an encoded word.
  function automatic logic [31:0] immgen(input logic [31:0] i, input logic [2:0] ft);
    case (ft)
      3'd1:    return {{20{i[31]}}, i[31:20]};
      3'd2:    return {{20{i[31]}}, i[31:25], i[11:7]};
      3'd3:    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd4:    return {i[31:12], 12'h000};
      3'd5:    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  // Monitor: compare the head of the scoreboard whenever a word is presented.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      model_cnt = 32'd0;
    end else begin
      chk("enc_count", enc_count, model_cnt);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("inst", inst, exp_q[0].inst);
          chk("err", {31'd0, err}, {31'd0, exp_q[0].err});
          if (exp_q[0].rt) chk("roundtrip", immgen(inst, exp_q[0].fmt), exp_q[0].imm);
          if (out_ready) begin
            void'(exp_q.pop_front());
            model_cnt = model_cnt + 32'd1;
          end
        end
      end
    end
  end

  task automatic send(input bundle_t b);
    fmt = b.fmt; opcode = b.opc; rd = b.rd; rs1 = b.rs1; rs2 = b.rs2;
    funct3 = b.f3; funct7 = b.f7; imm = b.imm;
    in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(b));
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    chk("accept_timeout", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 400 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain_remaining", exp_q.size(), 32'd0);
  endtask

  function automatic bundle_t mk(input logic [2:0] ft, input logic [6:0] opc,
                                 input logic [4:0] r, input logic [31:0] im);
    bundle_t b;
    b.fmt = ft; b.opc = opc; b.rd = r; b.rs1 = 5'd0; b.rs2 = 5'd0;
    b.f3 = 3'd0; b.f7 = 7'd0; b.imm = im;
    return b;
  endfunction

  task automatic directed(input bundle_t b, input logic [31:0] want, input logic want_err);
    send(b);
    chk("latency_out_valid", {31'd0, out_valid}, 32'd1);
    chk("directed_inst", inst, want);
    chk("directed_err", {31'd0, err}, {31'd0, want_err});
    @(posedge clk); #1;
  endtask

  function automatic bundle_t rand_bundle();
    bundle_t b;
    int      v;
    b.fmt = 3'($urandom_range(0, 7));
    b.opc = 7'($urandom); b.rd = 5'($urandom); b.rs1 = 5'($urandom);
    b.rs2 = 5'($urandom); b.f3 = 3'($urandom); b.f7 = 7'($urandom);
    if ($urandom_range(0, 3) == 0) begin
      b.imm = $urandom;
    end else begin
      case (b.fmt)
        3'd1, 3'd2: v = int'($urandom_range(0, 4095)) - 2048;
        3'd3:       v = (int'($urandom_range(0, 8191)) - 4096) & ~1;
        3'd4:       v = int'($urandom & 32'hFFFF_F000);
        3'd5:       v = (int'($urandom_range(0, 2097151)) - 1048576) & ~1;
        default:    v = int'($urandom);
      endcase
      b.imm = 32'(v);
    end
    return b;
  endfunction

  initial begin
    logic [31:0] cnt0;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    fmt = 3'd0; opcode = 7'd0; rd = 5'd0; rs1 = 5'd0; rs2 = 5'd0;
    funct3 = 3'd0; funct7 = 7'd0; imm = 32'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_inst", inst, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_enc_count", enc_count, 32'd0);

    out_ready = 1'b1;
    directed(mk(FMT_I, OPC_I_COMP, 5'd1, 32'hFFFF_FFFF), 32'hFFF0_0093, 1'b0);
    directed(mk(FMT_SB, OPC_SB, 5'd0, 32'd8), 32'h0000_0463, 1'b0);
    directed(mk(FMT_SB, OPC_SB, 5'd0, 32'd5), 32'h0000_0263, CHK_ON);
    directed(mk(FMT_U, OPC_U_LUI, 5'd5, 32'h1234_5000), 32'h1234_52B7, 1'b0);
    directed(mk(FMT_UJ, OPC_UJ, 5'd1, 32'h0000_0800), 32'h0010_00EF, 1'b0);
    directed(mk(3'd7, OPC_UJ, 5'd1, 32'h0000_0800), 32'h0000_0013, 1'b0);
    directed(mk(FMT_U, OPC_U_AUIPC, 5'd2, 32'h0000_0001), 32'h0000_0117, CHK_ON);

    // Backpressure: FIFO fills after two accepts, then drains in order.
    cnt0 = enc_count;
    out_ready = 1'b0;
    send(mk(FMT_I, OPC_I_LOAD, 5'd3, 32'd4));
    send(mk(FMT_I, OPC_I_JALR, 5'd4, 32'd8));
    chk("full_in_ready", {31'd0, in_ready}, 32'd0);
    fork
      send(mk(FMT_S, OPC_S, 5'd0, 32'hFFFF_FFF0));
      begin
        repeat (3) @(posedge clk);
        #2 out_ready = 1'b1;
      end
    join
    drain();
    chk("backpressure_count", enc_count - cnt0, 32'd3);

    // Reset while two words are buffered.
    out_ready = 1'b0;
    send(mk(FMT_I, OPC_I_COMP, 5'd6, 32'd1));
    send(mk(FMT_I, OPC_I_COMP, 5'd7, 32'd2));
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mid_rst_enc_count", enc_count, 32'd0);
    chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("mid_rst_inst", inst, 32'd0);

    // Random traffic with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 300; n++) send(rand_bundle());
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
